// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and defaults for the instruction fetch controller.
package fetch_pkg;
    typedef enum logic {RUN, FAULT} state_e;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int DEF_MEM_WORDS = 1024;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry in-order FIFO of {instruction, pc}; the head entry drives the outputs directly.
module fetch_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_i,
    output logic [31:0] data_o,
    output logic [31:0] pc_o,
    output logic [1:0]  occ_o
);
    logic [63:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]  occ_q, occ_d;
    logic        push_ok, pop_ok;

    assign push_ok = push_i && (occ_q != 2'd2 || pop_i);
    assign pop_ok  = pop_i && occ_q != 2'd0;

    // head only moves on a pop or when filling an empty/draining slot, which keeps outputs stable under backpressure
    always_comb begin
        occ_d  = flush_i ? 2'd0 : occ_q + 2'(push_ok) - 2'(pop_ok);
        head_d = head_q;
        tail_d = tail_q;
        if (!flush_i) begin
            if (pop_ok && occ_q == 2'd2)
                head_d = tail_q;
            if (push_ok && (occ_q == 2'd0 || (occ_q == 2'd1 && pop_ok)))
                head_d = {data_i, pc_i};
            if (push_ok && ((occ_q == 2'd1 && !pop_ok) || occ_q == 2'd2))
                tail_d = {data_i, pc_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            head_q <= 64'd0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk)
        tail_q <= tail_d;

    assign data_o = head_q[63:32];
    assign pc_o   = head_q[31:0];
    assign occ_o  = occ_q;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch with registered-read memory, 2-entry output buffer,
// redirect handling and a sticky fault on misaligned or out-of-range pc.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault
);
    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * WORD_BYTES);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ifpc_q, ifpc_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  occ;
    logic        pop, redir, want, bad, issue, push;

    assign pop   = inst_valid && inst_ready;
    assign redir = redirect_valid && state_q == RUN;
    // space check: entries after this edge plus the read we launch must fit in two slots
    assign want  = state_q == RUN && !redirect_valid
                && ({1'b0, occ} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
    assign bad   = pc_q[1:0] != 2'b00 || pc_q >= PC_LIMIT;
    assign issue = want && !bad;
    assign push  = inflight_q && !redir;

    always_comb begin
        state_d    = (want && bad) ? FAULT : state_q;
        pc_d       = redir ? redirect_pc : issue ? pc_q + 32'(WORD_BYTES) : pc_q;
        inflight_d = issue;
        ifpc_d     = issue ? pc_q : ifpc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            ifpc_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            ifpc_q     <= ifpc_d;
        end
    end

    fetch_buf u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(redir),
        .data_i (mem_data),
        .pc_i   (ifpc_q),
        .data_o (inst_data),
        .pc_o   (inst_pc),
        .occ_o  (occ)
    );

    assign mem_addr   = pc_q;
    assign inst_valid = occ != 2'd0;
    assign fault      = state_q == FAULT;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of streaming, backpressure, redirect, fault and async reset.
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr, mem_data, inst_data, inst_pc, redirect_pc;
    logic        inst_valid, inst_ready, redirect_valid, fault;
    logic [31:0] mem [1024];
    logic [31:0] exp_pc;
    int          checks = 0;
    int          errors = 0;

    fetch_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        mem_data <= mem[mem_addr[11:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // advance one cycle, first scoring any transfer that the coming edge will perform
    task automatic cyc();
        if (inst_valid && inst_ready && !redirect_valid) begin
            chk("xfer_pc", inst_pc, exp_pc);
            chk("xfer_data", inst_data, exp_pc >> 2);
            exp_pc += 32'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i;
        mem_data = 32'd0;
        rst_n = 1'b0;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        exp_pc = 32'd0;
        #1;
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // streaming: issue at first edge, valid after the second
        @(negedge clk);
        chk("lat1_valid", {31'd0, inst_valid}, 32'd0);
        chk("lat1_addr", mem_addr, 32'h4);
        @(negedge clk);
        chk("lat2_valid", {31'd0, inst_valid}, 32'd1);
        chk("lat2_pc", inst_pc, 32'h0);
        exp_pc = 32'h0;
        repeat (4) cyc();
        // backpressure: two entries held, no further issue
        inst_ready = 1'b0;
        repeat (5) cyc();
        chk("stall_valid", {31'd0, inst_valid}, 32'd1);
        chk("stall_pc", inst_pc, 32'h10);
        chk("stall_addr", mem_addr, 32'h18);
        inst_ready = 1'b1;
        repeat (6) cyc();
        chk("resume_cnt", exp_pc, 32'h28);
        // redirect with a full buffer
        inst_ready = 1'b0;
        repeat (2) cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        inst_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_valid", {31'd0, inst_valid}, 32'd0);
        chk("redir_addr", mem_addr, 32'h40);
        @(negedge clk);
        chk("redir_lat", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("redir_first", inst_pc, 32'h40);
        exp_pc = 32'h40;
        repeat (3) cyc();
        // redirect while a read is in flight mid-stream
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir2_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        exp_pc = 32'h100;
        repeat (3) cyc();
        chk("redir2_cnt", exp_pc, 32'h10C);
        // misaligned redirect target faults on the first issue attempt
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("mis_pre_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_addr", mem_addr, 32'h42);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("fault_redir_ign", mem_addr, 32'h42);
        repeat (3) cyc();
        chk("fault_no_valid", {31'd0, inst_valid}, 32'd0);
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        // run off the end of memory
        rst_n = 1'b0;
        #1;
        chk("rst2_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFE0;
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_pc = 32'hFE0;
        repeat (14) cyc();
        chk("end_last", exp_pc, 32'h1000);
        chk("end_fault", {31'd0, fault}, 32'd1);
        chk("end_valid", {31'd0, inst_valid}, 32'd0);
        chk("end_addr", mem_addr, 32'h1000);
        // async reset with a full buffer
        rst_n = 1'b0;
        @(negedge clk);
        inst_ready = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_valid", {31'd0, inst_valid}, 32'd1);
        chk("full_addr", mem_addr, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_fault", {31'd0, fault}, 32'd0);
        chk("arst_pc", inst_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("restart_lat", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        exp_pc = 32'h0;
        repeat (4) cyc();
        chk("restart_cnt", exp_pc, 32'h10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
